// File: rtl/rat_pkg.sv
// rat_pkg: shared animation state type and sprite geometry for the rat sprite slice.
package rat_pkg;
   typedef enum logic [1:0] {HIDDEN, RISING, UP, FALLING} rat_state_e;
   localparam int SPR_W  = 32;
   localparam int SPR_H  = 32;
   localparam int SPR_AW = 10;
endpackage

// File: rtl/rat_anim_fsm.sv
// rat_anim_fsm: pop-up animation FSM; latches pop/whack until the next frame tick and
// steps the revealed height h_o (0..32) on frame ticks.
// Ports: clk, reset (sync, active-high), frame_tick_i, pop_i, whack_i in;
//        h_o (revealed rows), rat_up_o (state is UP), whacked_o (accepted-whack pulse) out.
module rat_anim_fsm
   import rat_pkg::*;
#(
   parameter int STEP      = 4,
   parameter int UP_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick_i,
   input  logic       pop_i,
   input  logic       whack_i,
   output logic [5:0] h_o,
   output logic       rat_up_o,
   output logic       whacked_o
);
   localparam int TW = $clog2(UP_FRAMES + 1);
   rat_state_e    state_q, state_d;
   logic [5:0]    h_q, h_d, h_up, h_dn;
   logic [6:0]    h_sum;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          pop_q, pop_d, whk_q, whk_d, whacked_d, pop_e, whk_e;
   // a request arriving on the tick itself counts for that tick
   assign pop_e = pop_q | pop_i;
   assign whk_e = whk_q | whack_i;
   assign h_sum = {1'b0, h_q} + 7'(STEP);
   assign h_up  = h_sum >= 7'(SPR_H) ? 6'(SPR_H) : h_sum[5:0];
   assign h_dn  = h_q > 6'(STEP) ? h_q - 6'(STEP) : '0;
   assign h_o   = h_q;
   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      tmr_d     = tmr_q;
      pop_d     = pop_e;
      whk_d     = whk_e;
      whacked_d = 1'b0;
      if (frame_tick_i) begin
         pop_d = 1'b0;
         whk_d = 1'b0;
         case (state_q)
            HIDDEN: if (pop_e) begin
               state_d = RISING;
               h_d     = h_up;
            end
            RISING: if (whk_e) begin
               state_d   = FALLING;
               whacked_d = 1'b1;
            end else begin
               h_d = h_up;
               if (h_up == 6'(SPR_H)) begin
                  state_d = UP;
                  tmr_d   = '0;
               end
            end
            UP: if (whk_e) begin
               state_d   = FALLING;
               whacked_d = 1'b1;
            end else if (tmr_q == TW'(UP_FRAMES - 1)) state_d = FALLING;
            else tmr_d = tmr_q + 1'b1;
            FALLING: begin
               h_d     = h_dn;
               state_d = h_dn == '0 ? HIDDEN : FALLING;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= HIDDEN;
         h_q       <= '0;
         tmr_q     <= '0;
         pop_q     <= 1'b0;
         whk_q     <= 1'b0;
         rat_up_o  <= 1'b0;
         whacked_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         tmr_q     <= tmr_d;
         pop_q     <= pop_d;
         whk_q     <= whk_d;
         rat_up_o  <= state_d == UP;
         whacked_o <= whacked_d;
      end
   end
endmodule

// File: rtl/rat_sprite_gen.sv
// rat_sprite_gen: rat sprite pixel stage; region test and bitmap addressing for the hole,
// realigned to the 1-cycle bitmap RAM read, plus the pop-up animation.
// Ports: clk, reset, frame_tick, x/y (pixel), x0/y0 (hole), pop, whack, ram_data in;
//        ram_addr, sprite_rgb, sprite_on (1 cycle behind x/y), rat_up, whacked out.
module rat_sprite_gen
   import rat_pkg::*;
#(
   parameter int            CD        = 4,
   parameter logic [CD-1:0] TRANS     = '0,
   parameter int            STEP      = 4,
   parameter int            UP_FRAMES = 60
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_tick,
   input  logic [10:0]       x,
   input  logic [10:0]       y,
   input  logic [10:0]       x0,
   input  logic [10:0]       y0,
   input  logic              pop,
   input  logic              whack,
   output logic [SPR_AW-1:0] ram_addr,
   input  logic [CD-1:0]     ram_data,
   output logic [CD-1:0]     sprite_rgb,
   output logic              sprite_on,
   output logic              rat_up,
   output logic              whacked
);
   logic [10:0] x0r_q, y0r_q;
   logic        on_q, in_region;
   logic [5:0]  h;
   logic [11:0] x_end, y_bot, y_top;
   logic [4:0]  col, row;
   rat_anim_fsm #(.STEP(STEP), .UP_FRAMES(UP_FRAMES)) u_fsm (
      .clk(clk), .reset(reset), .frame_tick_i(frame_tick), .pop_i(pop), .whack_i(whack),
      .h_o(h), .rat_up_o(rat_up), .whacked_o(whacked)
   );
   // 12-bit bounds so a hole near column/row 2047 does not wrap back to 0
   assign x_end     = {1'b0, x0r_q} + 12'(SPR_W);
   assign y_bot     = {1'b0, y0r_q} + 12'(SPR_H);
   assign y_top     = y_bot - {6'b0, h};
   assign in_region = h != '0 && x >= x0r_q && {1'b0, x} < x_end
                      && {1'b0, y} >= y_top && {1'b0, y} < y_bot;
   // row 0 sits at the current top edge, so the bitmap top is revealed first
   assign col        = x[4:0] - x0r_q[4:0];
   assign row        = y[4:0] - y_top[4:0];
   assign ram_addr   = in_region ? {row, col} : '0;
   assign sprite_on  = on_q && ram_data != TRANS;
   assign sprite_rgb = sprite_on ? ram_data : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         x0r_q <= '0;
         y0r_q <= '0;
         on_q  <= 1'b0;
      end else begin
         if (frame_tick) begin
            x0r_q <= x0;
            y0r_q <= y0;
         end
         on_q <= in_region;
      end
   end
endmodule
